// File: rtl/button_ctrl_pkg.sv
// Shared types and constants for the front-panel button select controller.
// Contents:
//   cfg_target_t - which filter-bank target a configuration request addresses
//   state_t      - configuration port FSM state
//   *_BASE       - first button index of each selection group
//   onehot_index - index of the set bit in a one-hot button vector
//   pick_grant   - round-robin choice among pending targets
package button_ctrl_pkg;

   typedef enum logic [1:0] {
      TGT_FREQ = 2'd0,
      TGT_LP   = 2'd1,
      TGT_HP   = 2'd2
   } cfg_target_t;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } state_t;

   localparam int FREQ_BASE   = 0;
   localparam int LP_BASE     = 8;
   localparam int HP_BASE     = 12;
   localparam int NUM_BUTTONS = 16;

   // Only meaningful for a one-hot input; callers gate on $onehot.
   function automatic logic [3:0] onehot_index(input logic [NUM_BUTTONS-1:0] v);
      logic [3:0] idx;
      idx = '0;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
         if (v[i]) idx = 4'(i);
      end
      return idx;
   endfunction

   // First pending target at or after rr, in order freq -> lp -> hp -> freq.
   function automatic cfg_target_t pick_grant(input cfg_target_t rr, input logic [2:0] pend);
      case (rr)
         TGT_FREQ: return pend[0] ? TGT_FREQ : (pend[1] ? TGT_LP : TGT_HP);
         TGT_LP:   return pend[1] ? TGT_LP : (pend[2] ? TGT_HP : TGT_FREQ);
         default:  return pend[2] ? TGT_HP : (pend[0] ? TGT_FREQ : TGT_LP);
      endcase
   endfunction

   function automatic cfg_target_t rr_next(input cfg_target_t t);
      case (t)
         TGT_FREQ: return TGT_LP;
         TGT_LP:   return TGT_HP;
         default:  return TGT_FREQ;
      endcase
   endfunction

endpackage

// File: rtl/button_select_controller_if.sv
// Configuration port between the button controller and the filter bank.
//   cfg_req    - request valid, held until accepted
//   cfg_target - 0=freq, 1=lowpass, 2=highpass
//   cfg_value  - selection value for cfg_target
//   cfg_ack    - accept; a transfer happens when cfg_req && cfg_ack
// master: controller side; slave: filter bank side.
interface button_select_controller_if;
   logic       cfg_req;
   logic [1:0] cfg_target;
   logic [2:0] cfg_value;
   logic       cfg_ack;

   modport master (output cfg_req, output cfg_target, output cfg_value, input cfg_ack);
   modport slave  (input cfg_req, input cfg_target, input cfg_value, output cfg_ack);
endinterface

// File: rtl/button_select_controller_debouncer.sv
// Two-flop synchroniser plus debounce filter for a vector of raw buttons.
// A new vector is accepted once the synchronised input has matched the
// candidate for DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   clk, reset_n - clock, asynchronous active-low reset
//   raw_i        - asynchronous button levels
//   stable_o     - debounced button vector
module button_debouncer #(
   parameter int WIDTH           = 16,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] raw_i,
   output logic [WIDTH-1:0] stable_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sync1_q, sync2_q, cand_q, stable_q, stable_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d    = cnt_q;
      stable_d = stable_q;
      if (sync2_q != cand_q) begin
         cnt_d = '0;
      end else begin
         if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
         if (cnt_q == CNT_HIT) stable_d = cand_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         cand_q   <= '0;
         cnt_q    <= '0;
         stable_q <= '0;
      end else begin
         sync1_q  <= raw_i;
         sync2_q  <= sync1_q;
         cand_q   <= sync2_q;
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
      end
   end

   assign stable_o = stable_q;

endmodule

// File: rtl/button_select_controller.sv
// Front-panel controller for the 16 channel-strip selection buttons.
// Debounced single-button presses update the freq/lowpass/highpass
// selections; changed selections are sent to the filter bank over one
// shared req/ack port, round-robin across the three targets.
// Ports:
//   clk, reset_n     - clock, asynchronous active-low reset
//   buttons          - raw button levels, bit i high = pressed
//   freq_select      - frequency selection 0-7
//   lowpass_select   - lowpass selection 0-3
//   highpass_select  - highpass selection 0-3
//   cfg              - configuration port (master side)
//   busy             - request outstanding or update pending
module button_select_controller
   import button_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [NUM_BUTTONS-1:0]       buttons,
   output logic [2:0]                   freq_select,
   output logic [2:0]                   lowpass_select,
   output logic [2:0]                   highpass_select,
   button_select_controller_if.master   cfg,
   output logic                         busy
);

   logic [NUM_BUTTONS-1:0] stable, stable_prev_q;
   logic                   press_vld;
   logic [3:0]             press_idx;
   cfg_target_t            press_tgt;
   logic [2:0]             press_val;

   logic [2:0]  freq_q, freq_d, lp_q, lp_d, hp_q, hp_d;
   logic [2:0]  set_mask, pend_q, pend_d;
   cfg_target_t rr_q, rr_d, tgt_q, tgt_d, grant_tgt;
   logic [2:0]  val_q, val_d;
   logic        req_q, req_d;
   state_t      state_q, state_d;

   button_debouncer #(
      .WIDTH           (NUM_BUTTONS),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_debounce (
      .clk      (clk),
      .reset_n  (reset_n),
      .raw_i    (buttons),
      .stable_o (stable)
   );

   // Accept only a clean 0 -> one-hot step; chords and changes while any
   // button is still held never qualify.
   assign press_vld = (stable_prev_q == '0) && $onehot(stable);

   always_comb begin
      press_idx = onehot_index(stable);
      if (press_idx < 4'(LP_BASE)) begin
         press_tgt = TGT_FREQ;
         press_val = 3'(press_idx - 4'(FREQ_BASE));
      end else if (press_idx < 4'(HP_BASE)) begin
         press_tgt = TGT_LP;
         press_val = 3'(press_idx - 4'(LP_BASE));
      end else begin
         press_tgt = TGT_HP;
         press_val = 3'(press_idx - 4'(HP_BASE));
      end
   end

   always_comb begin
      freq_d   = freq_q;
      lp_d     = lp_q;
      hp_d     = hp_q;
      set_mask = 3'b000;
      if (press_vld) begin
         case (press_tgt)
            TGT_FREQ: begin freq_d = press_val; set_mask[0] = (press_val != freq_q); end
            TGT_LP:   begin lp_d   = press_val; set_mask[1] = (press_val != lp_q);   end
            default:  begin hp_d   = press_val; set_mask[2] = (press_val != hp_q);   end
         endcase
      end
   end

   always_comb begin
      state_d   = state_q;
      pend_d    = pend_q;
      rr_d      = rr_q;
      req_d     = req_q;
      tgt_d     = tgt_q;
      val_d     = val_q;
      grant_tgt = pick_grant(rr_q, pend_q);
      case (state_q)
         IDLE: begin
            if (pend_q != 3'b000) begin
               tgt_d   = grant_tgt;
               req_d   = 1'b1;
               state_d = REQ;
               case (grant_tgt)
                  TGT_FREQ: begin pend_d[0] = 1'b0; val_d = freq_q; end
                  TGT_LP:   begin pend_d[1] = 1'b0; val_d = lp_q;   end
                  default:  begin pend_d[2] = 1'b0; val_d = hp_q;   end
               endcase
            end
         end
         default: begin
            if (cfg.cfg_ack) begin
               req_d   = 1'b0;
               rr_d    = rr_next(tgt_q);
               state_d = IDLE;
            end
         end
      endcase
      // A fresh change beats a same-cycle grant so the newer value is re-sent.
      pend_d = pend_d | set_mask;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stable_prev_q <= '0;
         freq_q        <= '0;
         lp_q          <= '0;
         hp_q          <= '0;
         pend_q        <= 3'b111;
         rr_q          <= TGT_FREQ;
         tgt_q         <= TGT_FREQ;
         val_q         <= '0;
         req_q         <= 1'b0;
         state_q       <= IDLE;
      end else begin
         stable_prev_q <= stable;
         freq_q        <= freq_d;
         lp_q          <= lp_d;
         hp_q          <= hp_d;
         pend_q        <= pend_d;
         rr_q          <= rr_d;
         tgt_q         <= tgt_d;
         val_q         <= val_d;
         req_q         <= req_d;
         state_q       <= state_d;
      end
   end

   assign freq_select     = freq_q;
   assign lowpass_select  = lp_q;
   assign highpass_select = hp_q;
   assign cfg.cfg_req     = req_q;
   assign cfg.cfg_target  = tgt_q;
   assign cfg.cfg_value   = val_q;
   assign busy            = req_q | (|pend_q);

endmodule

// File: tb/tb_button_select_controller.sv
// Directed bench for button_select_controller with DEBOUNCE_CYCLES=4.
module tb_button_select_controller;
   import button_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] buttons;
   logic [2:0]  fs, ls, hs;
   logic        busy;

   button_select_controller_if cfg ();

   button_select_controller #(.DEBOUNCE_CYCLES(4)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .buttons         (buttons),
      .freq_select     (fs),
      .lowpass_select  (ls),
      .highpass_select (hs),
      .cfg             (cfg),
      .busy            (busy)
   );

   always #5 clk = ~clk;

   // ---------------- handshake monitor ----------------
   int         cyc = 0;
   int         hs_n = 0;
   logic [1:0] hs_tgt [64];
   logic [2:0] hs_val [64];
   int         hs_cyc [64];
   int         stab_err = 0;
   int         gap_err = 0;
   logic       prev_req = 1'b0, prev_hs = 1'b0;
   logic [1:0] prev_tgt = '0;
   logic [2:0] prev_val = '0;
   wire        hs_now = cfg.cfg_req && cfg.cfg_ack;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!reset_n) begin
         prev_req <= 1'b0;
         prev_hs  <= 1'b0;
      end else begin
         if (prev_req && !prev_hs && cfg.cfg_req &&
             (cfg.cfg_target != prev_tgt || cfg.cfg_value != prev_val))
            stab_err <= stab_err + 1;
         if (prev_hs && cfg.cfg_req) gap_err <= gap_err + 1;
         if (hs_now && hs_n < 64) begin
            hs_tgt[hs_n] <= cfg.cfg_target;
            hs_val[hs_n] <= cfg.cfg_value;
            hs_cyc[hs_n] <= cyc;
            hs_n         <= hs_n + 1;
         end
         prev_req <= cfg.cfg_req;
         prev_hs  <= hs_now;
         prev_tgt <= cfg.cfg_target;
         prev_val <= cfg.cfg_value;
      end
   end

   // ---------------- checking helpers ----------------
   int n_checks = 0;
   int n_fail = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_hs(input string name, input int idx, input int tgt, input int val);
      if (idx < hs_n) begin
         check({name, "_tgt"}, int'(hs_tgt[idx]), tgt);
         check({name, "_val"}, int'(hs_val[idx]), val);
      end else begin
         check({name, "_present"}, hs_n, idx + 1);
      end
   endtask

   typedef struct {
      logic [15:0] btn;
      int          hold;
      logic [2:0]  f, lp, hp;
      int          nreq;
      logic [1:0]  tgt;
      logic [2:0]  val;
   } vec_t;

   vec_t vecs [11];
   int   base;
   int   exp_t [4];
   int   exp_v [4];

   initial begin
      vecs[0]  = '{16'h0020, 12, 3'd5, 3'd0, 3'd0, 1, 2'd0, 3'd5};
      vecs[1]  = '{16'h0000, 10, 3'd5, 3'd0, 3'd0, 0, 2'd0, 3'd0};
      vecs[2]  = '{16'h0020, 12, 3'd5, 3'd0, 3'd0, 0, 2'd0, 3'd0};
      vecs[3]  = '{16'h0000, 10, 3'd5, 3'd0, 3'd0, 0, 2'd0, 3'd0};
      vecs[4]  = '{16'h1001, 12, 3'd5, 3'd0, 3'd0, 0, 2'd0, 3'd0};
      vecs[5]  = '{16'h0000, 10, 3'd5, 3'd0, 3'd0, 0, 2'd0, 3'd0};
      vecs[6]  = '{16'h0008, 12, 3'd3, 3'd0, 3'd0, 1, 2'd0, 3'd3};
      vecs[7]  = '{16'h000C, 12, 3'd3, 3'd0, 3'd0, 0, 2'd0, 3'd0};
      vecs[8]  = '{16'h0000, 10, 3'd3, 3'd0, 3'd0, 0, 2'd0, 3'd0};
      vecs[9]  = '{16'h8000, 12, 3'd3, 3'd0, 3'd3, 1, 2'd2, 3'd3};
      vecs[10] = '{16'h0000, 10, 3'd3, 3'd0, 3'd3, 0, 2'd0, 3'd0};

      reset_n     = 1'b0;
      buttons     = '0;
      cfg.cfg_ack = 1'b1;
      tick(3);

      // Reset state and default load
      check("rst_req", int'(cfg.cfg_req), 0);
      check("rst_tgt", int'(cfg.cfg_target), 0);
      check("rst_val", int'(cfg.cfg_value), 0);
      check("rst_sel", int'({fs, ls, hs}), 0);
      reset_n = 1'b1;
      base = hs_n;
      #1;
      check("busy_after_rst", int'(busy), 1);
      tick(8);
      check("dflt_count", hs_n - base, 3);
      check_hs("dflt0", base, 0, 0);
      check_hs("dflt1", base + 1, 1, 0);
      check_hs("dflt2", base + 2, 2, 0);
      if (base + 2 < hs_n) begin
         check("dflt_gap01", hs_cyc[base + 1] - hs_cyc[base], 2);
         check("dflt_gap12", hs_cyc[base + 2] - hs_cyc[base + 1], 2);
      end
      check("dflt_busy_done", int'(busy), 0);

      // Table-driven presses, releases, chords
      for (int i = 0; i < 11; i++) begin
         base = hs_n;
         buttons = vecs[i].btn;
         tick(vecs[i].hold);
         check($sformatf("vec%0d_sel", i), int'({fs, ls, hs}),
               int'({vecs[i].f, vecs[i].lp, vecs[i].hp}));
         check($sformatf("vec%0d_nreq", i), hs_n - base, vecs[i].nreq);
         check($sformatf("vec%0d_busy", i), int'(busy), 0);
         if (vecs[i].nreq > 0)
            check_hs($sformatf("vec%0d_req", i), hs_n - 1, int'(vecs[i].tgt), int'(vecs[i].val));
      end

      // Bouncing lowpass button, then a clean hold
      base = hs_n;
      for (int k = 0; k < 10; k++) begin
         buttons = (k % 2 == 0) ? 16'h0200 : 16'h0000;
         tick(2);
      end
      check("bounce_lp", int'(ls), 0);
      check("bounce_nreq", hs_n - base, 0);
      buttons = 16'h0200;
      tick(12);
      check("bounce_lp_final", int'(ls), 1);
      check("bounce_nreq_final", hs_n - base, 1);
      check_hs("bounce_req", hs_n - 1, 1, 1);
      buttons = 16'h0000;
      tick(10);

      // Reset while a request is outstanding
      cfg.cfg_ack = 1'b0;
      reset_n = 1'b0;
      tick(2);
      reset_n = 1'b1;
      tick(1);
      check("midreq_req_high", int'(cfg.cfg_req), 1);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_drop_req", int'(cfg.cfg_req), 0);
      tick(1);
      reset_n = 1'b1;
      cfg.cfg_ack = 1'b1;
      base = hs_n;
      tick(8);
      check("resend_count", hs_n - base, 3);
      check_hs("resend0", base, 0, 0);
      check_hs("resend1", base + 1, 1, 0);
      check_hs("resend2", base + 2, 2, 0);
      check("resend_sel", int'({fs, ls, hs}), 0);

      // Held request, queued targets, re-press of the target in flight
      cfg.cfg_ack = 1'b0;
      base = hs_n;
      buttons = 16'h0008; tick(12);
      check("held_freq", int'(fs), 3);
      check("held_req", int'(cfg.cfg_req), 1);
      check("held_tgt", int'(cfg.cfg_target), 0);
      check("held_val", int'(cfg.cfg_value), 3);
      buttons = 16'h0000; tick(10);
      buttons = 16'h0400; tick(12);
      check("held_lp", int'(ls), 2);
      buttons = 16'h0000; tick(10);
      buttons = 16'h2000; tick(12);
      check("held_hp", int'(hs), 1);
      buttons = 16'h0000; tick(10);
      buttons = 16'h0040; tick(12);
      check("held_freq2", int'(fs), 6);
      check("held_val_snap", int'(cfg.cfg_value), 3);
      check("held_busy", int'(busy), 1);
      check("held_no_hs", hs_n - base, 0);
      buttons = 16'h0000; tick(10);
      cfg.cfg_ack = 1'b1;
      tick(12);
      exp_t = '{0, 1, 2, 0};
      exp_v = '{3, 2, 1, 6};
      check("rr_count", hs_n - base, 4);
      for (int j = 0; j < 4; j++)
         check_hs($sformatf("rr%0d", j), base + j, exp_t[j], exp_v[j]);
      check("rr_busy_done", int'(busy), 0);
      check("stable_req", stab_err, 0);
      check("idle_gap", gap_err, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
